kbd_event_queue: RTL
====================

KBD_EVENT_QUEUE -- requirements
Module: kbd_event_queue

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-002 clk  in  1  single clock; monitor clock shared with the keyboard serial engine.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 kb_avail  in  1  data-available level from keyboard serial engine; high for >=1 cycle per received packet.
REQ-005 kb_is_mouse  in  1  1 = mouse packet, 0 = keyboard packet; stable while kb_avail high.
REQ-006 kb_data  in  16  packet payload; stable while kb_avail high.
REQ-007 ev_valid  out  1  head entry present (count != 0).
REQ-008 ev_data  out  17  head entry {is_mouse, data[15:0]}.
REQ-009 ev_pop  in  1  consumer accepts head this cycle.
REQ-010 ev_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-011 ovf  out  1  sticky overflow flag.
REQ-012 ovf_clr  in  1  clears ovf.
REQ-013 led_wr  in  1  host LED write strobe.
REQ-014 led_wdata  in  2  LED bits from host.
REQ-015 led_data_valid  out  1  one-cycle LED update strobe to keyboard serial engine.
REQ-016 led_data  out  2  LED bits accompanying led_data_valid.

Function
REQ-017 Capture: push {kb_is_mouse, kb_data} on the cycle kb_avail is sampled high and was low the previous cycle (rising edge); one push per high period regardless of duration.
REQ-018 Push latency: edge sampled at posedge N -> entry visible in ev_data/ev_count at posedge N+1.
REQ-019 ev_data shows head entry combinationally from storage whenever ev_valid=1; value undefined-but-stable when ev_valid=0.
REQ-020 Pop: ev_pop with ev_valid=1 removes head at that posedge; ev_pop with ev_valid=0 ignored, no state change.
REQ-021 Simultaneous push and pop: both occur, count unchanged; legal when full (no overflow) and when count=1.
REQ-022 Empty + push + ev_pop same cycle: pop ignored, entry stored, count becomes 1.
REQ-023 Full (count=DEPTH) + push without pop: new event dropped, stored entries untouched, ovf set next cycle.
REQ-024 ovf clears on ovf_clr; if a dropping push coincides with ovf_clr, set wins.
REQ-025 Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is separate, never exceeds DEPTH or underflows.
REQ-026 FIFO preserves order; keyboard and mouse events share one queue.
REQ-027 LED path: led_wr at posedge N -> led_data=led_wdata and led_data_valid=1 for exactly cycle N+1.
REQ-028 led_wr on consecutive cycles: each produces its own one-cycle strobe with its own data (strobe may stay high, data updates each cycle).
REQ-029 led_data holds last written value after strobe drops.

Reset
REQ-030 rst_n low asynchronously forces: pointers=0, ev_count=0, ev_valid=0, ovf=0, led_data_valid=0, led_data=2'b00, edge-detect history=1 (so a kb_avail already high at release is not captured).
REQ-031 Reset mid-operation discards all queued events and any pending LED strobe; storage contents need not be cleared.
REQ-032 Outputs must be registered or decoded from registers only; no combinational input->output path except storage read via pointer.

Structure
REQ-033 Shared package kbd_pkg holds: event width 17, KB_EV_MOUSE_BIT=16, LED width 2, default DEPTH.
REQ-034 Storage and pointers in one sub-module kbd_fifo (generic width/depth sync FIFO with full/empty/count); edge detect, overflow and LED logic in top.

Verification
REQ-035 Single keyboard packet: kb_avail high 5 cycles, kb_data=16'h3A12, is_mouse=0 -> exactly one entry, ev_data=17'h03A12 one cycle after edge, count=1.
REQ-036 Order/mix: push kbd 16'h0001, mouse 16'h8080, kbd 16'h0002 -> pops return 17'h00001, 17'h18080, 17'h00002, then ev_valid=0.
REQ-037 Overflow: DEPTH=8, 9 pushes no pops -> count=8, ovf=1, pops return first 8 only; ovf_clr -> ovf=0.
REQ-038 Full with simultaneous push+pop -> count stays 8, ovf stays 0, new entry appears last; 8+ wrap cycles keep order.
REQ-039 LED: led_wr with 2'b10 -> led_data_valid high exactly one cycle, led_data=2'b10 held afterward; back-to-back writes 2'b01,2'b11 -> two data values on consecutive cycles.
REQ-040 Reset: assert rst_n with count=5 and kb_avail held high across release -> count=0, ev_valid=0, no capture until kb_avail falls and rises again.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared widths and the event payload layout for the keyboard/mouse event queue.
package kbd_pkg;

  localparam int unsigned KB_DATA_W        = 16;
  localparam int unsigned KB_EV_W          = 17;
  localparam int unsigned KB_EV_MOUSE_BIT  = 16;
  localparam int unsigned KB_LED_W         = 2;
  localparam int unsigned KB_DEFAULT_DEPTH = 8;

  // Queue entry: source flag in the top bit, packet payload below it.
  typedef struct packed {
    logic                 is_mouse;
    logic [KB_DATA_W-1:0] data;
  } kb_event_t;

endpackage

// File: rtl/kbd_fifo.sv
// Generic single-clock FIFO with occupancy count; head is read straight from storage.
module kbd_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A push into a full queue is only accepted when a pop frees a slot the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kbd_event_queue.sv
// Queues keyboard/mouse packets from the serial engine for the host and
// forwards host LED writes back to the engine as one-cycle strobes.
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = KB_DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kb_avail,
  input  logic                   kb_is_mouse,
  input  logic [KB_DATA_W-1:0]   kb_data,
  output logic                   ev_valid,
  output logic [KB_EV_W-1:0]     ev_data,
  input  logic                   ev_pop,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   ovf,
  input  logic                   ovf_clr,
  input  logic                   led_wr,
  input  logic [KB_LED_W-1:0]    led_wdata,
  output logic                   led_data_valid,
  output logic [KB_LED_W-1:0]    led_data
);

  logic      avail_q;
  logic      push_q;
  kb_event_t ev_q;
  logic      fifo_full;
  logic      fifo_empty;
  logic      drop;

  // Rising-edge capture; history resets high so a level held across reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q <= 1'b1;
      push_q  <= 1'b0;
      ev_q    <= '0;
    end else begin
      avail_q <= kb_avail;
      push_q  <= kb_avail & ~avail_q;
      if (kb_avail & ~avail_q) begin
        ev_q.is_mouse <= kb_is_mouse;
        ev_q.data     <= kb_data;
      end
    end
  end

  kbd_fifo #(
    .WIDTH (KB_EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (ev_q),
    .pop   (ev_pop),
    .dout  (ev_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ev_count)
  );

  assign ev_valid = ~fifo_empty;
  // Full implies a valid head, so a same-cycle pop always makes room.
  assign drop     = push_q & fifo_full & ~ev_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_data_valid <= 1'b0;
      led_data       <= '0;
    end else begin
      led_data_valid <= led_wr;
      if (led_wr) led_data <= led_wdata;
    end
  end

endmodule
